// File: rtl/mult_div_ctrl_pkg.sv
// Shared types for the multiply/divide sequencing controller:
// state encoding, op codes and the data width.
package mult_div_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      MULT_WAIT  = 2'b01,
      DIV_LAUNCH = 2'b10,
      DIV_WAIT   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_MULT = 2'b00,
      OP_DIV  = 2'b01,
      OP_MTHI = 2'b10,
      OP_MTLO = 2'b11
   } op_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Execute-stage request bundle for the mult/div controller:
// request strobe and operands in, HI/LO and status out.
interface mult_div_ctrl_if
   import mult_div_pkg::*;
();
   logic            start;
   op_t             op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            done;
   logic            div_zero;

   modport master (
      output start, op, a, b,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_ctrl.sv
// Sequencer for the external multiplier and iterative divider;
// owns the architectural HI/LO registers and the busy stall.
module mult_div_ctrl
   import mult_div_pkg::*;
#(
   parameter int MULT_LAT = 2
) (
   input  logic            clock,
   input  logic            reset,
   mult_div_ctrl_if.slave  req,
   output logic [XLEN-1:0] mult_a,
   output logic [XLEN-1:0] mult_b,
   input  logic [XLEN-1:0] mult_hi,
   input  logic [XLEN-1:0] mult_low,
   output logic            div_start,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_quot,
   input  logic [XLEN-1:0] div_rem
);

   localparam int CW = $clog2(MULT_LAT + 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic            done_q;
   logic            dz_q;
   logic            busy_c;

   logic accept;
   logic b_zero;
   logic mult_go;
   logic div_go;
   logic div_z;
   logic mthi_go;
   logic mtlo_go;
   logic mult_fin;
   logic div_fin;

   assign accept   = (state == IDLE) && req.start;
   assign b_zero   = (req.b == '0);
   assign mult_go  = accept && (req.op == OP_MULT);
   assign div_go   = accept && (req.op == OP_DIV) && !b_zero;
   assign div_z    = accept && (req.op == OP_DIV) && b_zero;
   assign mthi_go  = accept && (req.op == OP_MTHI);
   assign mtlo_go  = accept && (req.op == OP_MTLO);
   assign mult_fin = (state == MULT_WAIT) && (cnt == '0);
   assign div_fin  = (state == DIV_WAIT) && div_done;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (mult_go)     state_nxt = MULT_WAIT;
            else if (div_go) state_nxt = DIV_LAUNCH;
         end
         MULT_WAIT:  if (mult_fin) state_nxt = IDLE;
         DIV_LAUNCH: state_nxt = DIV_WAIT;
         DIV_WAIT:   if (div_fin) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c    = (state != IDLE);
      div_start = (state == DIV_LAUNCH);
   end

   // The multiplier port naming is crossed: mult_low is the upper word.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         mult_a <= '0;
         mult_b <= '0;
         div_a  <= '0;
         div_b  <= '0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         if (cnt != '0) cnt <= cnt - CW'(1);
         unique case (1'b1)
            mult_go: begin
               mult_a <= req.a;
               mult_b <= req.b;
               cnt    <= CW'(MULT_LAT);
            end
            div_go: begin
               div_a <= req.a;
               div_b <= req.b;
            end
            div_z: begin
               done_q <= 1'b1;
               dz_q   <= 1'b1;
            end
            mthi_go: hi_q <= req.a;
            mtlo_go: lo_q <= req.a;
            mult_fin: begin
               lo_q   <= mult_hi;
               hi_q   <= mult_low;
               done_q <= 1'b1;
            end
            div_fin: begin
               lo_q   <= div_quot;
               hi_q   <= div_rem;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req.hi       = hi_q;
   assign req.lo       = lo_q;
   assign req.busy     = busy_c;
   assign req.done     = done_q;
   assign req.div_zero = dz_q;

endmodule
